// File: rtl/player_anim_ctrl.sv
// Per-player animation sequencer: buttons and hit events to sprite frame, paced by frame_tick.
// Optional punch-to-kick cancel on the last punch frame is enabled by defining ANIM_CANCEL_EN.
module player_anim_ctrl #(
    parameter int FRAME_HOLD    = 6,
    parameter int HITSTUN_TICKS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic [6:0] player_inputs,
    input  logic       hit,
    output logic [3:0] sprite_sel,
    output logic [2:0] anim_state,
    output logic       attack_active,
    output logic       anim_done,
    output logic       blocked,
    output logic       busy
);
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WALK    = 3'd1,
        ST_PUNCH   = 3'd2,
        ST_KICK    = 3'd3,
        ST_BLOCK   = 3'd4,
        ST_HITSTUN = 3'd5
    } state_e;

    localparam int HOLD_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    localparam int STUN_W = (HITSTUN_TICKS > 1) ? $clog2(HITSTUN_TICKS) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(FRAME_HOLD - 1);
    localparam logic [STUN_W-1:0] STUN_LAST = STUN_W'(HITSTUN_TICKS - 1);

    state_e              state_q, state_d, free_state;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [STUN_W-1:0]   stun_q, stun_d;
    logic [1:0]          frame_q, frame_d;
    logic [1:0]          btn_q;
    logic                punch_pend_q, punch_pend_d, kick_pend_q, kick_pend_d, hit_pend_q, hit_pend_d;
    logic                punch_req, kick_req, hit_req, enter;
    logic                done_d, blocked_d;
    logic [3:0]          sprite_d;
    logic                attack_d, busy_d;
    logic                done_q, blocked_q, attack_q, busy_q;
    logic [3:0]          sprite_q;

    // Edges or hits landing in the tick cycle itself count for that tick.
    assign punch_req = punch_pend_q | (player_inputs[4] & ~btn_q[0]);
    assign kick_req  = kick_pend_q  | (player_inputs[5] & ~btn_q[1]);
    assign hit_req   = hit_pend_q   | hit;

    always_comb begin
        if (player_inputs[6])                         free_state = ST_BLOCK;
        else if (punch_req)                           free_state = ST_PUNCH;
        else if (kick_req)                            free_state = ST_KICK;
        else if (player_inputs[0] ^ player_inputs[1]) free_state = ST_WALK;
        else                                          free_state = ST_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            hold_q       <= '0;
            stun_q       <= '0;
            frame_q      <= '0;
            btn_q        <= '0;
            punch_pend_q <= 1'b0;
            kick_pend_q  <= 1'b0;
            hit_pend_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            stun_q       <= stun_d;
            frame_q      <= frame_d;
            btn_q        <= player_inputs[5:4];
            punch_pend_q <= punch_pend_d;
            kick_pend_q  <= kick_pend_d;
            hit_pend_q   <= hit_pend_d;
        end
    end

    // NOTE: every signal gets a default before any branch, so no latch can be inferred.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        stun_d       = stun_q;
        frame_d      = frame_q;
        done_d       = 1'b0;
        blocked_d    = 1'b0;
        enter        = 1'b0;
        punch_pend_d = frame_tick ? 1'b0 : punch_req;
        kick_pend_d  = frame_tick ? 1'b0 : kick_req;
        hit_pend_d   = frame_tick ? 1'b0 : hit_req;
        if (frame_tick) begin
            if (hit_req) begin
                if (state_q == ST_BLOCK) begin
                    blocked_d = 1'b1;
                end else begin
                    state_d = ST_HITSTUN;
                    enter   = 1'b1;
                end
            end else if (state_q == ST_HITSTUN) begin
                if (stun_q == STUN_LAST) begin
                    state_d = free_state;
                    enter   = 1'b1;
                end else begin
                    stun_d = stun_q + STUN_W'(1);
                end
            end else if (state_q == ST_PUNCH || state_q == ST_KICK) begin
`ifdef ANIM_CANCEL_EN
                if (state_q == ST_PUNCH && frame_q == 2'd2 && kick_req) begin
                    state_d = ST_KICK;
                    enter   = 1'b1;
                end else
`endif
                if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + HOLD_W'(1);
                end else if (frame_q == ((state_q == ST_PUNCH) ? 2'd2 : 2'd3)) begin
                    done_d  = 1'b1;
                    state_d = free_state;
                    enter   = 1'b1;
                end else begin
                    hold_d  = '0;
                    frame_d = frame_q + 2'd1;
                end
            end else if (free_state != state_q) begin
                state_d = free_state;
                enter   = 1'b1;
            end else if (hold_q != HOLD_LAST) begin
                hold_d = hold_q + HOLD_W'(1);
            end else begin
                hold_d  = '0;
                frame_d = (state_q == ST_WALK) ? (frame_q ^ 2'd1) : 2'd0;
            end
            if (enter) begin
                hold_d  = '0;
                frame_d = '0;
                stun_d  = '0;
            end
        end
    end

    always_comb begin
        case (state_d)
            ST_WALK:    sprite_d = 4'd1 + {2'b00, frame_d};
            ST_PUNCH:   sprite_d = 4'd3 + {2'b00, frame_d};
            ST_KICK:    sprite_d = 4'd6 + {2'b00, frame_d};
            ST_BLOCK:   sprite_d = 4'd10;
            ST_HITSTUN: sprite_d = 4'd11;
            default:    sprite_d = 4'd0;
        endcase
        attack_d = (sprite_d == 4'd4) || (sprite_d == 4'd8);
        busy_d   = (state_d == ST_PUNCH) || (state_d == ST_KICK) || (state_d == ST_HITSTUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sprite_q  <= 4'd0;
            attack_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            blocked_q <= 1'b0;
        end else begin
            sprite_q  <= sprite_d;
            attack_q  <= attack_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            blocked_q <= blocked_d;
        end
    end

    assign sprite_sel    = sprite_q;
    assign anim_state    = state_q;
    assign attack_active = attack_q;
    assign anim_done     = done_q;
    assign blocked       = blocked_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_player_anim_ctrl.sv
// Self-checking bench for player_anim_ctrl (FRAME_HOLD=6, HITSTUN_TICKS=20); expected outputs go through a queue.
module tb_player_anim_ctrl;
    typedef struct packed {
        logic [3:0] sprite;
        logic [2:0] state;
        logic       attack;
        logic       done;
        logic       blk;
        logic       busy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic [6:0] player_inputs = '0;
    logic       hit = 1'b0;
    logic [3:0] sprite_sel;
    logic [2:0] anim_state;
    logic       attack_active, anim_done, blocked, busy;

    exp_t exp_q[$];
    exp_t got, exp;
    int   checks = 0;
    int   errors = 0;

    player_anim_ctrl #(.FRAME_HOLD(6), .HITSTUN_TICKS(20)) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .player_inputs(player_inputs), .hit(hit),
        .sprite_sel(sprite_sel), .anim_state(anim_state), .attack_active(attack_active),
        .anim_done(anim_done), .blocked(blocked), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic exp_t mk(input int s, input int st, input bit a, input bit d, input bit b, input bit bz);
        exp_t e;
        e.sprite = 4'(s);
        e.state  = 3'(st);
        e.attack = a;
        e.done   = d;
        e.blk    = b;
        e.busy   = bz;
        return e;
    endfunction

    function automatic exp_t observe();
        exp_t e;
        e.sprite = sprite_sel;
        e.state  = anim_state;
        e.attack = attack_active;
        e.done   = anim_done;
        e.blk    = blocked;
        e.busy   = busy;
        return e;
    endfunction

    // One frame_tick cycle; hit and extra input bits may be asserted in that same cycle.
    task automatic drive_tick(input bit with_hit, input logic [6:0] mask);
        @(negedge clk);
        frame_tick = 1'b1;
        hit = with_hit;
        player_inputs = player_inputs | mask;
        @(negedge clk);
        frame_tick = 1'b0;
        hit = 1'b0;
        player_inputs = player_inputs & ~mask;
    endtask

    task automatic press(input int bitn);
        @(negedge clk);
        player_inputs[bitn] = 1'b1;
        @(negedge clk);
        player_inputs[bitn] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
        repeat (2) @(negedge clk);
        got = observe(); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_hold got=%h exp=%h", got, exp); end
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
            drive_tick(1'b0, 7'h00);
            got = observe(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL reset_idle_tick%0d got=%h exp=%h", k, got, exp); end
        end
    endtask

    task automatic test_walk();
        player_inputs[1] = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            exp_q.push_back(mk(1 + ((k - 1) / 6) % 2, 1, 0, 0, 0, 0));
            drive_tick(1'b0, 7'h00);
            got = observe(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL walk_tick%0d got=%h exp=%h", k, got, exp); end
        end
        player_inputs[0] = 1'b1;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
        drive_tick(1'b0, 7'h00);
        got = observe(); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL walk_both_held got=%h exp=%h", got, exp); end
        player_inputs[1:0] = 2'b00;
    endtask

    task automatic test_punch();
        press(4);
        for (int k = 1; k <= 19; k++) begin
            if (k <= 18) exp_q.push_back(mk(3 + (k - 1) / 6, 2, ((k - 1) / 6) == 1, 0, 0, 1));
            else         exp_q.push_back(mk(0, 0, 0, 1, 0, 0));
            drive_tick(1'b0, 7'h00);
            got = observe(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL punch_tick%0d got=%h exp=%h", k, got, exp); end
        end
        @(negedge clk);
        checks++;
        if (anim_done !== 1'b0) begin errors++; $display("FAIL punch_done_width got=%b exp=0", anim_done); end
    endtask

    task automatic test_block();
        player_inputs[6] = 1'b1;
        exp_q.push_back(mk(10, 4, 0, 0, 0, 0));
        drive_tick(1'b0, 7'h00);
        got = observe(); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL block_enter got=%h exp=%h", got, exp); end
        @(negedge clk); hit = 1'b1;
        @(negedge clk); hit = 1'b0;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(mk(10, 4, 0, 0, 1, 0));
            drive_tick(bit'(k), 7'h00);
            got = observe(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL block_hit%0d got=%h exp=%h", k, got, exp); end
            @(negedge clk);
            checks++;
            if (blocked !== 1'b0) begin errors++; $display("FAIL block_pulse_width%0d got=%b exp=0", k, blocked); end
        end
        player_inputs[6] = 1'b0;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
        drive_tick(1'b0, 7'h00);
        got = observe(); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL block_release got=%h exp=%h", got, exp); end
    endtask

    task automatic test_kick_hit();
        press(5);
        for (int k = 1; k <= 8; k++) begin
            exp_q.push_back(mk(6 + (k - 1) / 6, 3, 0, 0, 0, 1));
            drive_tick(1'b0, 7'h00);
            got = observe(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL kick_tick%0d got=%h exp=%h", k, got, exp); end
        end
        @(negedge clk); hit = 1'b1;
        @(negedge clk); hit = 1'b0;
        for (int k = 1; k <= 21; k++) begin
            if (k <= 20) exp_q.push_back(mk(11, 5, 0, 0, 0, 1));
            else         exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
            drive_tick(1'b0, 7'h00);
            got = observe(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL hitstun_tick%0d got=%h exp=%h", k, got, exp); end
        end
    endtask

    task automatic test_priority_reset();
        @(negedge clk); player_inputs[5:4] = 2'b11;
        @(negedge clk); player_inputs[5:4] = 2'b00;
        for (int k = 1; k <= 7; k++) begin
            exp_q.push_back(mk(3 + (k - 1) / 6, 2, k == 7, 0, 0, 1));
            drive_tick(1'b0, 7'h00);
            got = observe(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL priority_tick%0d got=%h exp=%h", k, got, exp); end
        end
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
        #2 rst = 1'b1;
        #1;
        got = observe(); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL async_reset got=%h exp=%h", got, exp); end
        @(negedge clk); rst = 1'b0;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
        drive_tick(1'b0, 7'h00);
        got = observe(); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL after_reset got=%h exp=%h", got, exp); end
    endtask

    task automatic test_cancel();
        press(4);
        for (int k = 1; k <= 13; k++) begin
            exp_q.push_back(mk(3 + (k - 1) / 6, 2, ((k - 1) / 6) == 1, 0, 0, 1));
            drive_tick(1'b0, 7'h00);
            got = observe(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL cancel_setup%0d got=%h exp=%h", k, got, exp); end
        end
`ifdef ANIM_CANCEL_EN
        exp_q.push_back(mk(6, 3, 0, 0, 0, 1));
        drive_tick(1'b0, 7'h20);
        got = observe(); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL cancel_to_kick got=%h exp=%h", got, exp); end
`else
        for (int k = 14; k <= 19; k++) begin
            if (k <= 18) exp_q.push_back(mk(5, 2, 0, 0, 0, 1));
            else         exp_q.push_back(mk(0, 0, 0, 1, 0, 0));
            drive_tick(1'b0, (k == 14) ? 7'h20 : 7'h00);
            got = observe(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL nocancel_tick%0d got=%h exp=%h", k, got, exp); end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_walk();
        test_punch();
        test_block();
        test_kick_hit();
        test_priority_reset();
        test_cancel();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/player_anim_ctrl.md
# player_anim_ctrl

Animation sequencer for one fighter's 128×128 sprite. It turns debounced button inputs and hit events into an animation state machine, paced by the VGA frame tick. It drives the sprite frame select used to offset the sprite ROM address, plus gameplay strobes (active attack frame, attack complete, blocked hit). It sits between the input/game logic and the player sprite ROM / pixel mux; one instance is used per player.

## Interface
- `FRAME_HOLD`, 6: frame ticks each animation frame is displayed (≥1).
- `HITSTUN_TICKS`, 20: frame ticks spent in HITSTUN (≥1).
- `clk` in 1: pixel/system clock.
- `rst` in 1: reset. One clock; reset is asynchronous and active-high.
- `frame_tick` in 1: one-cycle pulse per VGA frame (end of active video).
- `player_inputs` in 7: level inputs. [0] left, [1] right, [2] jump (unused here), [3] crouch (unused), [4] punch, [5] kick, [6] block.
- `hit` in 1: one-cycle pulse when the opponent lands an attack on this player.
- `sprite_sel` out 4: sprite frame number. The ROM base address is `sprite_sel`×16384.
- `anim_state` out 3: IDLE=0, WALK=1, PUNCH=2, KICK=3, BLOCK=4, HITSTUN=5.
- `attack_active` out 1: high while the current frame is an attack's active (hitbox) frame.
- `anim_done` out 1: one-cycle pulse when PUNCH or KICK completes.
- `blocked` out 1: one-cycle pulse when a hit is absorbed in BLOCK.
- `busy` out 1: high in PUNCH, KICK, HITSTUN.

## Operation
- Rising-edge detect on punch and kick uses a registered copy of `player_inputs`. An edge sets `punch_pend` / `kick_pend`. `hit` sets `hit_pend`.
- All pend flags are evaluated and then cleared on every `frame_tick`. Unconsumed requests are dropped, not buffered.
- Decisions happen only on `frame_tick`, in priority order:
  1. `hit_pend`. In BLOCK, pulse `blocked` and stay in BLOCK. Otherwise go to HITSTUN and reset its counter; this also applies when already in HITSTUN and aborts any attack.
  2. State is PUNCH, KICK, or HITSTUN: advance the timers only.
  3. Block held: go to BLOCK.
  4. `punch_pend`: go to PUNCH.
  5. `kick_pend`: go to KICK.
  6. Exactly one of left/right held: go to WALK.
  7. Otherwise: go to IDLE.
- `hold_cnt` (0..FRAME_HOLD-1) increments per tick. On a tick when it equals FRAME_HOLD-1, it wraps to 0 and `frame_idx` advances. Any state entry zeroes `hold_cnt` and `frame_idx`.
- Sprite map:
  - IDLE → 0
  - WALK → 1,2 looping
  - PUNCH → 3,4,5
  - KICK → 6,7,8,9
  - BLOCK → 10
  - HITSTUN → 11
- `attack_active` is high for sprites 4 and 8.
- Attack end: advancing past the last frame pulses `anim_done`. On the same tick, the next state is chosen by rules 3–7 using current levels and pends.
- HITSTUN: `stun_cnt` counts ticks. On the tick when it reaches HITSTUN_TICKS-1, the next state is chosen by rules 3–7.
- Left and right both held counts as no movement.

## Timing
- All outputs are registered and update on the clock edge following the `frame_tick` cycle (1-cycle latency).
- `anim_done` and `blocked` are high for exactly one cycle.
- `hit` or an edge arriving in the same cycle as `frame_tick` is counted for that tick.
- Reset values:
  - state IDLE
  - `sprite_sel` 0
  - `anim_state` 0
  - `attack_active`, `anim_done`, `blocked`, `busy` 0
  - all counters and pends 0
- Reset mid-animation returns to IDLE immediately (asynchronous).
- Worst-case PUNCH duration is 3×FRAME_HOLD ticks. KICK is 4×FRAME_HOLD ticks.

## Configuration
- `ANIM_CANCEL_EN` defined: a `kick_pend` evaluated on any tick while PUNCH shows sprite 5 moves directly to KICK. `anim_done` does not pulse for the cancelled punch.
- `ANIM_CANCEL_EN` undefined: kick requests during PUNCH are dropped. No cancel logic is synthesized.

## Test plan
- After reset, 3 ticks with no inputs → `sprite_sel`=0, `anim_state`=0, all strobes 0.
- Right held, FRAME_HOLD=6, 24 ticks → enters WALK; `sprite_sel` alternates 1/2 every 6 ticks.
- Punch pressed once, no other inputs → PUNCH with sprites 3,4,5 for 6 ticks each; `attack_active` high only during sprite 4; `anim_done` pulses once after 18 ticks; then IDLE.
- Block held, then `hit` → `blocked` pulses one cycle after the next tick; state stays 4.
- `hit` during KICK sprite 7 → HITSTUN (`sprite_sel`=11) for 20 ticks; no `anim_done`; then IDLE.
- With `ANIM_CANCEL_EN`, kick edge during sprite 5 → next tick gives `sprite_sel`=6 and no `anim_done`. Without the macro, the punch completes and the kick is ignored.
